// File: rtl/hpdcache_pkg.sv
// Shared memory-response definitions: response codes and upsizer geometry helper.
package hpdcache_pkg;

  localparam logic [1:0] HPDCACHE_MEM_RESP_OK  = 2'b00;
  localparam logic [1:0] HPDCACHE_MEM_RESP_NOK = 2'b01;

  // Geometry of a narrow-to-wide upsizer: lanes per wide word and lane counter width
  typedef struct packed {
    logic [31:0] ratio;
    logic [31:0] cnt_width;
  } hpdcache_upsize_cfg_t;

  function automatic hpdcache_upsize_cfg_t hpdcache_upsize_cfg(
    input int unsigned narrow_width,
    input int unsigned wide_width
  );
    hpdcache_upsize_cfg_t cfg;
    cfg.ratio     = 32'(wide_width / narrow_width);
    cfg.cnt_width = (cfg.ratio > 32'd1) ? 32'($clog2(cfg.ratio)) : 32'd1;
    return cfg;
  endfunction

endpackage

// File: rtl/hpdcache_mem_resp_read_upsizer.sv
// Packs narrow memory read-response beats into full-width beats for the cache.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   nrw_valid_i/nrw_ready_o       narrow beat handshake (ready is combinational)
//   nrw_data_i/id_i/error_i/last_i narrow beat payload
//   wide_valid_o/wide_ready_i     wide response handshake (registered output)
//   wide_data_o/id_o/error_o/last_o wide response payload
module hpdcache_mem_resp_read_upsizer
  import hpdcache_pkg::*;
#(
  parameter int unsigned NarrowWidth = 128,
  parameter int unsigned WideWidth   = 512,
  parameter int unsigned IdWidth     = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   nrw_valid_i,
  output logic                   nrw_ready_o,
  input  logic [NarrowWidth-1:0] nrw_data_i,
  input  logic [IdWidth-1:0]     nrw_id_i,
  input  logic [1:0]             nrw_error_i,
  input  logic                   nrw_last_i,
  output logic                   wide_valid_o,
  input  logic                   wide_ready_i,
  output logic [WideWidth-1:0]   wide_data_o,
  output logic [IdWidth-1:0]     wide_id_o,
  output logic [1:0]             wide_error_o,
  output logic                   wide_last_o
);

  localparam hpdcache_upsize_cfg_t Cfg = hpdcache_upsize_cfg(NarrowWidth, WideWidth);
  localparam int unsigned Ratio    = Cfg.ratio;
  localparam int unsigned CntWidth = Cfg.cnt_width;
  localparam logic [CntWidth-1:0] LastLane = CntWidth'(Ratio - 1);

  // Parameter legality
  if ((NarrowWidth < 8) || ((NarrowWidth & (NarrowWidth - 1)) != 0)) begin : g_bad_narrow
    $error("NarrowWidth must be a power of two and at least 8");
  end
  if ((WideWidth < NarrowWidth) || ((WideWidth % NarrowWidth) != 0) ||
      ((Ratio & (Ratio - 1)) != 0)) begin : g_bad_wide
    $error("WideWidth must be a power-of-two multiple of NarrowWidth");
  end

  logic [CntWidth-1:0]  cnt_q;
  logic [WideWidth-1:0] acc_q;
  logic [IdWidth-1:0]   id_q;
  logic [1:0]           err_q;

  logic                 completing_c;
  logic                 accept_c;
  logic [WideWidth-1:0] merged_data_c;
  logic [IdWidth-1:0]   merged_id_c;
  logic [1:0]           merged_err_c;

  assign completing_c = (cnt_q == LastLane) || nrw_last_i;
  // Only a completing beat needs room in the output register
  assign nrw_ready_o  = !completing_c || !wide_valid_o || wide_ready_i;
  assign accept_c     = nrw_valid_i && nrw_ready_o;

  // Accumulator with the current beat dropped into lane cnt_q; upper lanes stay zero
  always_comb begin
    merged_data_c = acc_q;
    for (int unsigned l = 0; l < Ratio; l++) begin
      if (CntWidth'(l) == cnt_q) begin
        merged_data_c[l*NarrowWidth +: NarrowWidth] = nrw_data_i;
      end
    end
  end

  assign merged_id_c  = (cnt_q == '0) ? nrw_id_i : id_q;
  // First non-OK code of the word wins
  assign merged_err_c = (err_q == HPDCACHE_MEM_RESP_OK) ? nrw_error_i : err_q;

  // Lane accumulation and output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      id_q         <= '0;
      err_q        <= HPDCACHE_MEM_RESP_OK;
      wide_valid_o <= 1'b0;
      wide_data_o  <= '0;
      wide_id_o    <= '0;
      wide_error_o <= HPDCACHE_MEM_RESP_OK;
      wide_last_o  <= 1'b0;
    end else begin
      if (wide_valid_o && wide_ready_i) begin
        wide_valid_o <= 1'b0;
      end
      if (accept_c) begin
        if (completing_c) begin
          wide_valid_o <= 1'b1;
          wide_data_o  <= merged_data_c;
          wide_id_o    <= merged_id_c;
          wide_error_o <= merged_err_c;
          wide_last_o  <= nrw_last_i;
          cnt_q        <= '0;
          acc_q        <= '0;
          err_q        <= HPDCACHE_MEM_RESP_OK;
        end else begin
          acc_q <= merged_data_c;
          cnt_q <= cnt_q + CntWidth'(1);
          id_q  <= merged_id_c;
          err_q <= merged_err_c;
        end
      end
    end
  end

  // The ID must not change within a word
  a_id_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (nrw_valid_i && nrw_ready_o && (cnt_q != '0)) |-> (nrw_id_i == id_q))
    else $error("upsizer: ID changed in the middle of a word");

endmodule

// File: tb/tb_hpdcache_mem_resp_read_upsizer.sv
// Randomized scoreboard bench for the read-response upsizer (default geometry).
module tb_hpdcache_mem_resp_read_upsizer;

  localparam int unsigned NW    = 128;
  localparam int unsigned WW    = 512;
  localparam int unsigned IW    = 7;
  localparam int unsigned RATIO = WW / NW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          nrw_valid_i = 1'b0;
  logic          nrw_ready_o;
  logic [NW-1:0] nrw_data_i = '0;
  logic [IW-1:0] nrw_id_i = '0;
  logic [1:0]    nrw_error_i = '0;
  logic          nrw_last_i = 1'b0;
  logic          wide_valid_o;
  logic          wide_ready_i = 1'b1;
  logic [WW-1:0] wide_data_o;
  logic [IW-1:0] wide_id_o;
  logic [1:0]    wide_error_o;
  logic          wide_last_o;

  hpdcache_mem_resp_read_upsizer #(
    .NarrowWidth(NW), .WideWidth(WW), .IdWidth(IW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .nrw_valid_i(nrw_valid_i), .nrw_ready_o(nrw_ready_o),
    .nrw_data_i(nrw_data_i), .nrw_id_i(nrw_id_i),
    .nrw_error_i(nrw_error_i), .nrw_last_i(nrw_last_i),
    .wide_valid_o(wide_valid_o), .wide_ready_i(wide_ready_i),
    .wide_data_o(wide_data_o), .wide_id_o(wide_id_o),
    .wide_error_o(wide_error_o), .wide_last_o(wide_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [WW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    err;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: beats gathered for the word in progress
  logic [NW-1:0] m_beats[$];
  logic [IW-1:0] m_id;
  logic [1:0]    m_err;
  bit            expect_valid_next = 0;
  int            rdy_mode = 0; // 0 always ready, 1 random, 2 stalled

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_beats.delete();
    m_err = 2'b00;
    m_id  = '0;
  endtask

  // Builds the expected wide word from the accepted beats of a word
  task automatic model_accept(input logic [NW-1:0] d, input logic [IW-1:0] id,
                              input logic [1:0] err, input logic last);
    exp_t e;
    if (m_beats.size() == 0) m_id = id;
    if (m_err == 2'b00) m_err = err;
    m_beats.push_back(d);
    if (m_beats.size() == RATIO || last) begin
      e.data = '0;
      for (int i = 0; i < m_beats.size(); i++) e.data[i*NW +: NW] = m_beats[i];
      e.id   = m_id;
      e.err  = m_err;
      e.last = last;
      exp_q.push_back(e);
      expect_valid_next = 1;
      model_reset();
    end
  endtask

  // Presents one beat and waits for the handshake; entered and left just after a rising edge
  task automatic send_beat(input logic [NW-1:0] d, input logic [IW-1:0] id,
                           input logic [1:0] err, input logic last);
    bit accepted = 0;
    bit rdy;
    bit comp;
    int waited = 0;
    nrw_valid_i = 1'b1;
    nrw_data_i  = d;
    nrw_id_i    = id;
    nrw_error_i = err;
    nrw_last_i  = last;
    while (!accepted) begin
      @(negedge clk_i);
      rdy  = nrw_ready_o;
      comp = (m_beats.size() == RATIO - 1) || last;
      if (!comp || wide_ready_i) check("nrw_ready", WW'(rdy), WW'(1));
      @(posedge clk_i);
      if (rdy) accepted = 1;
      else if (++waited > 200) begin
        check("beat_accept_timeout", WW'(0), WW'(1));
        break;
      end
    end
    if (accepted) model_accept(d, id, err, last);
    #1;
    nrw_valid_i = 1'b0;
  endtask

  function automatic logic [NW-1:0] pattern(input int k);
    logic [3:0] n;
    n = 4'(k);
    return {32{n}};
  endfunction

  function automatic logic [NW-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // datasel: 0 random, 1 lane-index pattern; errs: explicit codes, random if empty
  task automatic send_burst(input int len, input logic [IW-1:0] id, input int datasel,
                            input logic [1:0] errs[$]);
    logic [NW-1:0] d;
    logic [1:0]    e;
    for (int i = 0; i < len; i++) begin
      d = (datasel == 1) ? pattern(i) : rand_beat();
      if (errs.size() > 0) e = errs[i % errs.size()];
      else e = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_beat(d, id, e, i == len - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    check("drain_queue_empty", WW'(exp_q.size()), WW'(0));
  endtask

  // Ready driver
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        0: wide_ready_i = 1'b1;
        1: wide_ready_i = ($urandom_range(0, 3) != 0);
        default: wide_ready_i = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor and completion-latency check
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (expect_valid_next) begin
        check("latency_valid", WW'(wide_valid_o), WW'(1));
        expect_valid_next = 0;
      end
      if (rst_ni && wide_valid_o && wide_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wide_beat", WW'(1), WW'(0));
        end else begin
          e = exp_q.pop_front();
          check("wide_data", wide_data_o, e.data);
          check("wide_id", WW'(wide_id_o), WW'(e.id));
          check("wide_error", WW'(wide_error_o), WW'(e.err));
          check("wide_last", WW'(wide_last_o), WW'(e.last));
        end
      end
    end
  end

  initial begin
    logic [1:0] no_errs[$];
    logic [1:0] zero_errs[$];
    logic [1:0] mix_errs[$];
    zero_errs = '{2'd0};
    mix_errs  = '{2'd0, 2'd1, 2'd0, 2'd2};
    model_reset();

    // Reset state
    repeat (3) @(negedge clk_i);
    check("reset_valid", WW'(wide_valid_o), WW'(0));
    check("reset_data", wide_data_o, WW'(0));
    check("reset_id", WW'(wide_id_o), WW'(0));
    check("reset_error", WW'(wide_error_o), WW'(0));
    check("reset_last", WW'(wide_last_o), WW'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(2);

    // Full burst, lane pattern data
    send_burst(4, 7'h15, 1, zero_errs);
    idle(2);
    // Two words back-to-back
    send_burst(8, 7'h2a, 0, zero_errs);
    idle(1);
    // Short burst, then a burst that must restart at lane 0
    send_burst(2, 7'h11, 1, zero_errs);
    send_burst(4, 7'h12, 1, zero_errs);
    drain();

    // Output stalled for 6 cycles during an 8-beat burst
    fork
      send_burst(8, 7'h40, 0, zero_errs);
      begin
        repeat (2) @(posedge clk_i);
        rdy_mode = 2;
        repeat (6) @(posedge clk_i);
        rdy_mode = 0;
      end
    join
    drain();

    // Sticky error: first non-OK code wins, cleared for the next word
    send_burst(4, 7'h05, 0, mix_errs);
    send_burst(4, 7'h05, 0, zero_errs);
    drain();

    // Reset in the middle of a word
    send_beat(rand_beat(), 7'h22, 2'd3, 1'b0);
    send_beat(rand_beat(), 7'h22, 2'd0, 1'b0);
    rst_ni = 1'b0;
    model_reset();
    exp_q.delete();
    expect_valid_next = 0;
    @(negedge clk_i);
    check("reset_mid_valid", WW'(wide_valid_o), WW'(0));
    @(negedge clk_i);
    check("reset_mid_valid_hold", WW'(wide_valid_o), WW'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(1);
    send_burst(4, 7'h33, 1, zero_errs);
    drain();

    // Random bursts with random backpressure and gaps
    rdy_mode = 1;
    for (int b = 0; b < 40; b++) begin
      send_burst($urandom_range(1, 9), 7'($urandom_range(0, 127)), 0, no_errs);
      idle($urandom_range(0, 2));
    end
    rdy_mode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
